// File: rtl/ras_pkg.sv
// Shared types and sizing helpers for the return address stack.
package ras_pkg;

  // Behaviour of a push that arrives while the stack is full.
  typedef enum logic {
    RAS_OVF_ERR  = 1'b0,  // flag err, drop the push
    RAS_OVF_WRAP = 1'b1   // overwrite the oldest entry
  } ras_ovf_e;

  localparam int RAS_DEF_WIDTH = 16;
  localparam int RAS_DEF_DEPTH = 8;

  // Pointer width for a power-of-two depth (at least 2).
  function automatic int ras_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: must hold 0..depth inclusive.
  function automatic int ras_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int RAS_DEF_PTR_W = ras_ptr_w(RAS_DEF_DEPTH);
  localparam int RAS_DEF_CNT_W = ras_cnt_w(RAS_DEF_DEPTH);

  // Checkpoint record for the default geometry; the top declares the
  // same layout sized by its own parameters.
  typedef struct packed {
    logic [RAS_DEF_PTR_W-1:0] ptr;
    logic [RAS_DEF_CNT_W-1:0] count;
    logic [RAS_DEF_WIDTH-1:0] top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_if.sv
// Fetch-side command/status bundle for the return address stack.
// push, pop, ckpt_save and ckpt_restore are single-cycle strobes sampled on
// the rising edge; there is no backpressure, every strobe is consumed in the
// cycle it is presented and err reports a rejected strobe in that same cycle.
interface ras_ckpt_if
  import ras_pkg::*;
#(
  parameter int WIDTH = RAS_DEF_WIDTH,
  parameter int DEPTH = RAS_DEF_DEPTH
);
  localparam int CNT_W = ras_cnt_w(DEPTH);

  logic             push;
  logic [WIDTH-1:0] new_data;
  logic             pop;
  logic             ckpt_save;
  logic             ckpt_restore;
  logic [WIDTH-1:0] top_of_stack;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             ckpt_valid;
  logic             err;

  modport master (
    output push, new_data, pop, ckpt_save, ckpt_restore,
    input  top_of_stack, count, empty, full, ckpt_valid, err
  );

  modport slave (
    input  push, new_data, pop, ckpt_save, ckpt_restore,
    output top_of_stack, count, empty, full, ckpt_valid, err
  );
endinterface

// File: rtl/ras_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one
// combinational read port, no reset (contents are don't-care until written).
module ras_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/ras_ckpt.sv
// Return address stack with configurable overflow policy, same-cycle
// push+pop, and a single checkpoint for mispredict recovery.
module ras_ckpt
  import ras_pkg::*;
#(
  parameter int       WIDTH    = RAS_DEF_WIDTH,
  parameter int       DEPTH    = RAS_DEF_DEPTH,
  parameter ras_ovf_e OVF_MODE = RAS_OVF_ERR
) (
  input logic       clk,
  input logic       rst_n,
  ras_ckpt_if.slave bus
);
  localparam int PTR_W = ras_ptr_w(DEPTH);
  localparam int CNT_W = ras_cnt_w(DEPTH);

  typedef struct packed {
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] top;
  } ckpt_t;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ckpt_t            ckpt_q, ckpt_d;
  logic             ckpt_valid_q, ckpt_valid_d;

  logic             mem_we;
  logic [PTR_W-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             err_c;

  logic not_empty, is_full;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  assign not_empty = (count_q != '0);
  assign is_full   = (count_q == CNT_W'(DEPTH));
  // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
  assign ptr_inc   = ptr_q + PTR_W'(1);
  assign ptr_dec   = ptr_q - PTR_W'(1);

  ras_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (ptr_q),
    .rdata (mem_rdata)
  );

  // Next-state: restore wins and swallows everything else; otherwise
  // push&pop > pop > push, with save captured from pre-edge state.
  always_comb begin
    ptr_d        = ptr_q;
    count_d      = count_q;
    ckpt_d       = ckpt_q;
    ckpt_valid_d = ckpt_valid_q;
    mem_we       = 1'b0;
    mem_waddr    = ptr_q;
    mem_wdata    = bus.new_data;
    err_c        = 1'b0;

    if (bus.ckpt_restore && ckpt_valid_q) begin
      ptr_d        = ckpt_q.ptr;
      count_d      = ckpt_q.count;
      mem_we       = 1'b1;
      mem_waddr    = ckpt_q.ptr;
      mem_wdata    = ckpt_q.top;
      ckpt_valid_d = 1'b0;
    end else begin
      if (bus.ckpt_restore) err_c = 1'b1;

      if (bus.push && bus.pop && not_empty) begin
        // Call in the return slot: replace the top in place.
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
      end else if (bus.pop && !bus.push) begin
        if (not_empty) begin
          ptr_d   = ptr_dec;
          count_d = count_q - CNT_W'(1);
        end else begin
          err_c = 1'b1;
        end
      end else if (bus.push) begin
        if (!is_full) begin
          ptr_d     = ptr_inc;
          count_d   = count_q + CNT_W'(1);
          mem_we    = 1'b1;
          mem_waddr = ptr_inc;
        end else if (OVF_MODE == RAS_OVF_WRAP) begin
          ptr_d     = ptr_inc;
          mem_we    = 1'b1;
          mem_waddr = ptr_inc;
        end else begin
          err_c = 1'b1;
        end
      end

      if (bus.ckpt_save) begin
        ckpt_d.ptr   = ptr_q;
        ckpt_d.count = count_q;
        ckpt_d.top   = mem_rdata;
        ckpt_valid_d = 1'b1;
      end
    end
  end

  // State registers; mem contents are deliberately left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= '0;
      count_q      <= '0;
      ckpt_q       <= '0;
      ckpt_valid_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      ckpt_q       <= ckpt_d;
      ckpt_valid_q <= ckpt_valid_d;
    end
  end

  assign bus.top_of_stack = not_empty ? mem_rdata : '0;
  assign bus.count        = count_q;
  assign bus.empty        = !not_empty;
  assign bus.full         = is_full;
  assign bus.ckpt_valid   = ckpt_valid_q;
  assign bus.err          = err_c;
endmodule

// File: tb/tb_ras_ckpt.sv
// Bench for ras_ckpt: an ERR-mode and a WRAP-mode instance see identical
// stimulus; a circular-buffer reference model predicts each cycle's err and
// post-edge state, and a monitor compares them against the DUTs.
module tb_ras_ckpt;
  import ras_pkg::*;

  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ras_ckpt_if #(.WIDTH(16), .DEPTH(D)) if0 ();
  ras_ckpt_if #(.WIDTH(16), .DEPTH(D)) if1 ();

  ras_ckpt #(.WIDTH(16), .DEPTH(D), .OVF_MODE(RAS_OVF_ERR)) dut_err (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  ras_ckpt #(.WIDTH(16), .DEPTH(D), .OVF_MODE(RAS_OVF_WRAP)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Clock.
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected record: {err, ckpt_valid, full, empty, count[3:0], top[15:0]}.
  logic [23:0] exp_q0[$];
  logic [23:0] exp_q1[$];

  // Reference model, one slot per overflow mode (0 = ERR, 1 = WRAP).
  int mm [2][D];
  int mp [2];
  int mc [2];
  int sp [2];
  int sc [2];
  int st [2];
  bit mv [2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      mp[m] = 0; mc[m] = 0; sp[m] = 0; sc[m] = 0; st[m] = 0; mv[m] = 1'b0;
    end
  endfunction

  // Apply one cycle of commands to model m; returns the expected err.
  function automatic bit model_step(input int m, input bit pu, input bit po,
                                    input bit sv, input bit rs, input int d);
    bit e = 1'b0;
    int op = mp[m];
    int oc = mc[m];
    int otop = mm[m][op];
    if (rs && mv[m]) begin
      mp[m] = sp[m];
      mc[m] = sc[m];
      mm[m][sp[m]] = st[m];
      mv[m] = 1'b0;
    end else begin
      if (rs) e = 1'b1;
      if (pu && po && oc > 0) begin
        mm[m][op] = d;
      end else if (po && !pu) begin
        if (oc > 0) begin
          mp[m] = (op + D - 1) % D;
          mc[m] = oc - 1;
        end else e = 1'b1;
      end else if (pu) begin
        if (oc < D || m == 1) begin
          mp[m] = (op + 1) % D;
          mm[m][mp[m]] = d;
          if (oc < D) mc[m] = oc + 1;
        end else e = 1'b1;
      end
      if (sv) begin
        sp[m] = op; sc[m] = oc; st[m] = otop; mv[m] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [23:0] model_view(input int m, input bit e);
    logic [15:0] top = (mc[m] > 0) ? 16'(mm[m][mp[m]]) : 16'h0;
    return {e, mv[m], (mc[m] == D), (mc[m] == 0), 4'(mc[m]), top};
  endfunction

  // Driver: present one cycle of commands and queue the expected response.
  task automatic cycle(input bit pu, input bit po, input bit sv, input bit rs,
                       input logic [15:0] d);
    bit e0, e1;
    @(negedge clk);
    if0.push = pu; if0.pop = po; if0.ckpt_save = sv; if0.ckpt_restore = rs; if0.new_data = d;
    if1.push = pu; if1.pop = po; if1.ckpt_save = sv; if1.ckpt_restore = rs; if1.new_data = d;
    e0 = model_step(0, pu, po, sv, rs, int'(d));
    e1 = model_step(1, pu, po, sv, rs, int'(d));
    exp_q0.push_back(model_view(0, e0));
    exp_q1.push_back(model_view(1, e1));
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic cmp_rec(input string tag, input logic [23:0] e, input logic a_err,
                         input logic a_cv, input logic a_full, input logic a_empty,
                         input logic [3:0] a_cnt, input logic [15:0] a_top);
    chk({tag, ".err"}, int'(a_err), int'(e[23]));
    chk({tag, ".ckpt_valid"}, int'(a_cv), int'(e[22]));
    chk({tag, ".full"}, int'(a_full), int'(e[21]));
    chk({tag, ".empty"}, int'(a_empty), int'(e[20]));
    chk({tag, ".count"}, int'(a_cnt), int'(e[19:16]));
    chk({tag, ".top"}, int'(a_top), int'(e[15:0]));
  endtask

  // Monitor: err mid-cycle, state just after the edge.
  initial begin
    logic err0, err1;
    logic [23:0] e0, e1;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q0.size() == 0) continue;
      err0 = if0.err;
      err1 = if1.err;
      @(posedge clk);
      #1;
      e0 = exp_q0.pop_front();
      e1 = exp_q1.pop_front();
      cmp_rec("err_mode", e0, err0, if0.ckpt_valid, if0.full, if0.empty, if0.count, if0.top_of_stack);
      cmp_rec("wrap_mode", e1, err1, if1.ckpt_valid, if1.full, if1.empty, if1.count, if1.top_of_stack);
    end
  end

  // Stimulus.
  initial begin
    if0.push = 0; if0.pop = 0; if0.ckpt_save = 0; if0.ckpt_restore = 0; if0.new_data = '0;
    if1.push = 0; if1.pop = 0; if1.ckpt_save = 0; if1.ckpt_restore = 0; if1.new_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.count", int'(if0.count), 0);
    chk("reset.empty", int'(if0.empty), 1);
    chk("reset.top", int'(if0.top_of_stack), 0);
    chk("reset.ckpt_valid", int'(if1.ckpt_valid), 0);

    // Basic push/pop, underflow.
    cycle(1, 0, 0, 0, 16'h1000);
    cycle(1, 0, 0, 0, 16'h2000);
    cycle(1, 0, 0, 0, 16'h3000);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0);

    // Fill, overflow in both policies, drain, underflow.
    for (int i = 1; i <= 10; i++) cycle(1, 0, 0, 0, 16'(i));
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 16'h0);

    // Same-cycle push+pop, non-empty and empty.
    cycle(1, 0, 0, 0, 16'h1111);
    cycle(1, 1, 0, 0, 16'h2222);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(1, 1, 0, 0, 16'h3333);
    cycle(0, 1, 0, 0, 16'h0);

    // Checkpoint save/restore repairing an overwritten top.
    cycle(1, 0, 0, 0, 16'h000A);
    cycle(1, 0, 0, 0, 16'h000B);
    cycle(0, 0, 1, 0, 16'h0);
    cycle(0, 1, 0, 0, 16'h0);
    cycle(1, 0, 0, 0, 16'h000C);
    cycle(1, 0, 0, 0, 16'h000D);
    cycle(1, 1, 1, 1, 16'h0EEE);
    cycle(0, 1, 0, 0, 16'h0);

    // Restore without a checkpoint still lets the push through.
    cycle(1, 0, 0, 1, 16'h0005);
    cycle(0, 0, 1, 0, 16'h0);
    cycle(1, 0, 0, 0, 16'h0006);
    idle();

    // Asynchronous reset between edges with a checkpoint held.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.count", int'(if0.count), 0);
    chk("async_rst.ckpt_valid", int'(if0.ckpt_valid), 0);
    chk("async_rst.wrap_count", int'(if1.count), 0);
    chk("async_rst.wrap_ckpt_valid", int'(if1.ckpt_valid), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 35,
            $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
            16'($urandom_range(0, 16'hFFFF)));
    end
    idle();

    repeat (3) @(negedge clk);
    chk("drain.queue", exp_q0.size() + exp_q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ras_ckpt.md
Name: ras_ckpt

Overview:
Parametrised return address stack for the CPU fetch stage, successor to the fixed 8-entry, 16-bit stack.
- Calls push the return PC; returns pop it, and the top of stack predicts the return target.
- Adds configurable depth and width, a selectable overflow policy, and same-cycle push+pop (call-in-return slot).
- Adds a single checkpoint that fetch saves on a predicted branch and restores on a mispredict.

Parameters:
WIDTH, 16, bits per stored return address
DEPTH, 8, number of entries; power of two, at least 2
OVF_MODE, RAS_OVF_ERR, overflow policy from ras_pkg: RAS_OVF_ERR = push on full flags err and is dropped; RAS_OVF_WRAP = push on full overwrites the oldest entry

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
push  in  1  push new_data this cycle
new_data  in  WIDTH  address to push
pop  in  1  pop the top entry this cycle
ckpt_save  in  1  capture a checkpoint of the current state
ckpt_restore  in  1  roll back to the saved checkpoint
top_of_stack  out  WIDTH  current top entry, combinational from registered state
count  out  $clog2(DEPTH+1)  number of valid entries
empty  out  1  count == 0
full  out  1  count == DEPTH
ckpt_valid  out  1  a checkpoint is held
err  out  1  combinational, high in the same cycle as an illegal operation

Behaviour:
- Storage is a circular buffer mem[DEPTH], with top pointer ptr of $clog2(DEPTH) bits; all index arithmetic is modulo DEPTH.
- Reset (asynchronous): ptr=0, count=0, ckpt_valid=0, checkpoint registers cleared. mem is not reset. Release is synchronous to clk.
- top_of_stack = mem[ptr] when count>0, otherwise 0. Zero-cycle read latency; an update is visible the cycle after the edge.
- Operation priority: ckpt_restore, then push&pop, then pop, then push. ckpt_save is evaluated independently of these.
- push only:
  - count<DEPTH: ptr+1, write mem[ptr+1], count+1.
  - full with RAS_OVF_ERR: err=1, no state change.
  - full with RAS_OVF_WRAP: ptr+1, write mem[ptr+1] (oldest entry lost), count stays DEPTH, err=0.
- pop only:
  - count>0: ptr-1, count-1.
  - count==0: err=1, no state change.
- push&pop together:
  - count>0: overwrite mem[ptr] with new_data; ptr and count unchanged; err=0.
  - count==0: behaves as push only; err=0.
- ckpt_save: on the edge, capture ptr, count and mem[ptr] as seen before that edge's update; set ckpt_valid=1. A later save overwrites an earlier one.
- ckpt_restore with ckpt_valid=1:
  - Set ptr and count to the saved values.
  - Rewrite mem[saved ptr] with the saved top; this repairs a slot overwritten by a later push.
  - Clear ckpt_valid. All push, pop and save in the same cycle are ignored.
- ckpt_restore with ckpt_valid=0: err=1; push, pop and save in that cycle still execute normally.
- Only the top entry is repaired on restore; deeper corruption is accepted prediction inaccuracy.
- Reset asserted mid-operation: immediate return to the reset state; any checkpoint is discarded.

Decomposition:
- ras_pkg holds:
  - ras_ovf_e enum {RAS_OVF_ERR, RAS_OVF_WRAP};
  - a ras_ckpt_t struct typedef {ptr, count, top};
  - helper localparams for pointer and count widths.
- One sub-module, ras_mem: a DEPTH x WIDTH register file with one write port and one combinational read port, no reset. ras_ckpt keeps the pointer, count and checkpoint logic.

Test Plan:
- Reset, then push 0x1000,0x2000,0x3000 -> count=3, top=0x3000; pop twice -> top=0x1000, count=1; pop, pop -> second pop err=1, count=0, top=0.
- DEPTH=8, OVF_MODE=ERR: push 0x0001..0x0008, then push 0x0009 -> err=1, full=1, top=0x0008; eight pops return 8..1.
- DEPTH=8, OVF_MODE=WRAP: push 0x0001..0x000A -> count=8, err never set; eight pops return 0x000A down to 0x0003, then empty=1.
- push 0x1111, then push&pop with 0x2222 -> count=1, top=0x2222. From empty, push&pop with 0x3333 -> count=1, top=0x3333, err=0.
- push 0xA, 0xB; ckpt_save; pop; push 0xC; push 0xD; ckpt_restore -> count=2, top=0xB, ckpt_valid=0; pop -> top=0xA.
- ckpt_restore with ckpt_valid=0 plus push 0x5 -> err=1, count+1, top=0x5. Assert rst_n mid-sequence with a checkpoint held -> count=0 and ckpt_valid=0 immediately, without waiting for a clock edge.
